pmp_csr_regs: RTL and testbench
===============================

// Module: pmp_csr_regs
// PURPOSE
//   Holds the 16 pmpaddr and 4 pmpcfg CSRs and drives them, registered, into pmp_check.
//   Accepts single-beat CSR read/write requests from the core's CSR unit over a valid/ready handshake.
//   Enforces lock-bit (L) write protection, TOR lock of the preceding address, and WARL legalisation.
//   Returns one response per request, one cycle after the request is accepted.
// PARAMETERS
//   NUM_ENTRIES   16   PMP entries; fixed at 16 in this revision (4 pmpcfg x 4 bytes)
// PORTS
//   clk                          in   1   clock; all state updates on its rising edge
//   rst_n                        in   1   asynchronous reset, active-low
//   csr_req_valid                in   1   request present
//   csr_req_ready                out  1   block can accept a request
//   csr_req_we                   in   1   1 = write, 0 = read
//   csr_req_addr                 in   12  CSR address (0x3A0-0x3A3 pmpcfg, 0x3B0-0x3BF pmpaddr)
//   csr_req_wdata                in   32  full write value; core resolves set/clear before issuing
//   csr_rsp_valid                out  1   response present
//   csr_rsp_ready                in   1   consumer takes the response
//   csr_rsp_rdata                out  32  register value after the access; 0 on error
//   csr_rsp_err                  out  1   address not a PMP CSR
//   pmpaddr0_data..pmpaddr15_data out 32 each  current pmpaddr registers, to pmp_check
//   pmpcfg0_data..pmpcfg3_data   out  32 each  current pmpcfg registers, to pmp_check
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - all pmpaddr/pmpcfg = 0; csr_rsp_valid = 0; csr_rsp_rdata = 0; csr_rsp_err = 0
//     - a pending response is discarded
//   Handshake FSM: IDLE -> RESP on accept (csr_req_valid && csr_req_ready).
//     - RESP -> IDLE on csr_rsp_ready without a new accept; RESP -> RESP on csr_rsp_ready with a new accept.
//     - csr_req_ready = !csr_rsp_valid || csr_rsp_ready, giving full throughput when the consumer is ready.
//     - Response fields are registered and held stable while csr_rsp_valid && !csr_rsp_ready.
//   Latency: register update and response both appear 1 cycle after accept. pmp_check sees the new value in that same cycle.
//   pmpcfg write, per byte i (entry 4*k+i):
//     - The byte is left unchanged if its stored L=1.
//     - The whole byte is also left unchanged if the written R=0 and W=1 (reserved combination).
//     - Otherwise the byte is written with bits[6:5] forced to 0.
//     - Each byte is filtered independently, so a mixed locked/unlocked word updates only the unlocked bytes.
//   pmpaddr[i] write is ignored if cfg[i].L=1, or if i<15 and cfg[i+1].L=1 && cfg[i+1].A==TOR.
//     All 32 bits are writable otherwise (RV32, G=0).
//   Lock is sticky: only reset clears L. A write setting L takes effect for the next request.
//     Example: setting L with A=TOR on entry i locks pmpaddr[i-1] from the next request on.
//   Ignored writes are not errors: csr_rsp_err=0 and rdata = unchanged stored value.
//   Unmapped address: csr_rsp_err=1, rdata=0, no state change, for both read and write.
//   Reads have no side effects.
// STRUCTURE
//   cep_define package gains:
//     - CSR_PMPCFG0 = 12'h3A0 and CSR_PMPADDR0 = 12'h3B0
//     - pmp_a_e enum {OFF, TOR, NA4, NAPOT}
//   The existing pmpcfg struct typedef (L, A, X, W, R) is reused.
//   Sub-module pmp_cfg_byte_wr (combinational, instanced 16x):
//     - inputs: old byte, new byte, write-enable
//     - output: legalised next byte
//   The top level holds the registers, the address decode, the TOR-lock computation and the response FSM.
// TESTING
//   1. Write 0x3A0 <- 0x0000_001F, then read 0x3A0 -> rdata 0x0000_001F, err=0, rsp 1 cycle after accept.
//   2. Write 0x3A0 <- 0x0000_0082 (byte0 L=1, W=1, R=0) -> byte0 unchanged (reserved R/W), rdata 0.
//      Then write 0x0000_0089 -> cfg byte0 = 0x89. A later write of 0x0000_0000 leaves 0x89.
//   3. Lock TOR:
//      - Write pmpcfg0 byte1 <- 0x8F (L, TOR, XWR), then write 0x3B0 <- 0x1234_5678 -> pmpaddr0 stays 0.
//      - Write 0x3B2 <- 0x0000_1000 -> pmpaddr2_data = 0x0000_1000.
//   4. Mixed lock: bytes 0 and 2 locked, write 0x3A0 <- 0x0707_0707 -> only bytes 1 and 3 become 0x07.
//   5. Read 0x3C0 -> err=1, rdata=0. Hold csr_rsp_ready=0 for 3 cycles -> response stable, csr_req_ready=0.
//      Back-to-back requests with csr_rsp_ready=1 -> one response per cycle.
//   6. Assert rst_n=0 while csr_rsp_valid=1 -> rsp_valid drops immediately, all 20 output registers read 0.

Source files
------------

// File: rtl/cep_define.sv
// -----------------------------------------------------------------------------
// cep_define
//   Shared definitions for the PMP CSR block: CSR base addresses, the pmpcfg
//   address-matching mode enum and the packed pmpcfg byte layout.
// -----------------------------------------------------------------------------
package cep_define;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    // Bit positions inside a pmpcfg byte, for places that work on raw bytes
    localparam int CFG_L_BIT = 7;
    localparam int CFG_A_LSB = 3;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       L;
        logic [1:0] rsvd;
        pmp_a_e     A;
        logic       X;
        logic       W;
        logic       R;
    } pmpcfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/pmp_cfg_byte_wr.sv
// -----------------------------------------------------------------------------
// pmp_cfg_byte_wr
//   Combinational write filter for one pmpcfg byte.
//   Ports:
//     old_byte_i  [7:0]  currently stored byte
//     new_byte_i  [7:0]  byte lane of the write data
//     we_i               this byte's word is being written
//     next_byte_o [7:0]  legalised next value of the byte
// -----------------------------------------------------------------------------
module pmp_cfg_byte_wr (
    input  logic [7:0] old_byte_i,
    input  logic [7:0] new_byte_i,
    input  logic       we_i,
    output logic [7:0] next_byte_o
);
    import cep_define::*;

    pmpcfg_t old_c;
    pmpcfg_t new_c;
    pmpcfg_t legal_c;

    assign old_c = pmpcfg_t'(old_byte_i);
    assign new_c = pmpcfg_t'(new_byte_i);

    always_comb begin
        legal_c      = new_c;
        legal_c.rsvd = 2'b00;
        // Locked bytes and the reserved R=0/W=1 encoding keep the old byte whole
        if (we_i && !old_c.L && !(!new_c.R && new_c.W)) begin
            next_byte_o = legal_c;
        end else begin
            next_byte_o = old_c;
        end
    end

endmodule

// File: rtl/pmp_csr_regs.sv
// -----------------------------------------------------------------------------
// pmp_csr_regs
//   Holds the 16 pmpaddr and 4 pmpcfg CSRs and drives them, registered, to
//   pmp_check. Serves single-beat CSR requests over valid/ready with one
//   response per request, one cycle after acceptance.
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     csr_req_valid/ready              request handshake
//     csr_req_we, addr[11:0], wdata    request: write flag, CSR address, data
//     csr_rsp_valid/ready              response handshake
//     csr_rsp_rdata[31:0], csr_rsp_err register value after access, bad address
//     pmpaddrN_data, pmpcfgN_data      current register contents to pmp_check
// -----------------------------------------------------------------------------
module pmp_csr_regs #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic        csr_req_we,
    input  logic [11:0] csr_req_addr,
    input  logic [31:0] csr_req_wdata,
    output logic        csr_rsp_valid,
    input  logic        csr_rsp_ready,
    output logic [31:0] csr_rsp_rdata,
    output logic        csr_rsp_err,
    output logic [31:0] pmpaddr0_data,
    output logic [31:0] pmpaddr1_data,
    output logic [31:0] pmpaddr2_data,
    output logic [31:0] pmpaddr3_data,
    output logic [31:0] pmpaddr4_data,
    output logic [31:0] pmpaddr5_data,
    output logic [31:0] pmpaddr6_data,
    output logic [31:0] pmpaddr7_data,
    output logic [31:0] pmpaddr8_data,
    output logic [31:0] pmpaddr9_data,
    output logic [31:0] pmpaddr10_data,
    output logic [31:0] pmpaddr11_data,
    output logic [31:0] pmpaddr12_data,
    output logic [31:0] pmpaddr13_data,
    output logic [31:0] pmpaddr14_data,
    output logic [31:0] pmpaddr15_data,
    output logic [31:0] pmpcfg0_data,
    output logic [31:0] pmpcfg1_data,
    output logic [31:0] pmpcfg2_data,
    output logic [31:0] pmpcfg3_data
);
    import cep_define::*;

    localparam int NUM_CFG = NUM_ENTRIES / 4;

    logic [31:0] pmpaddr_q [NUM_ENTRIES];
    logic [31:0] pmpaddr_d [NUM_ENTRIES];
    logic [31:0] pmpcfg_q  [NUM_CFG];
    logic [31:0] pmpcfg_d  [NUM_CFG];
    logic [7:0]  cfg_byte_q [NUM_ENTRIES];
    logic [7:0]  cfg_byte_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] addr_locked;
    logic [NUM_CFG-1:0]     cfg_we;

    rsp_state_e  state_q, state_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic       req_accept;
    logic       write_acc;
    logic       sel_cfg;
    logic       sel_addr;
    logic [3:0] sel_idx;

    assign req_accept = csr_req_valid && csr_req_ready;
    assign write_acc  = req_accept && csr_req_we;
    assign sel_cfg    = (csr_req_addr[11:2] == CSR_PMPCFG0[11:2]);
    assign sel_addr   = (csr_req_addr[11:4] == CSR_PMPADDR0[11:4]);
    assign sel_idx    = csr_req_addr[3:0];

    always_comb begin
        for (int k = 0; k < NUM_CFG; k++) begin
            cfg_we[k] = write_acc && sel_cfg && (sel_idx[1:0] == 2'(k));
        end
    end

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
        localparam int WI = e / 4;
        localparam int BI = e % 4;

        assign cfg_byte_q[e] = pmpcfg_q[WI][8*BI +: 8];

        pmp_cfg_byte_wr u_cfg_byte (
            .old_byte_i  (cfg_byte_q[e]),
            .new_byte_i  (csr_req_wdata[8*BI +: 8]),
            .we_i        (cfg_we[WI]),
            .next_byte_o (cfg_byte_d[e])
        );

        // pmpaddr[e] is also the bottom of a locked TOR range owned by entry e+1
        if (e < NUM_ENTRIES - 1) begin : g_tor
            assign addr_locked[e] = cfg_byte_q[e][CFG_L_BIT]
                || (cfg_byte_q[e+1][CFG_L_BIT]
                    && (cfg_byte_q[e+1][CFG_A_LSB +: 2] == TOR));
        end else begin : g_last
            assign addr_locked[e] = cfg_byte_q[e][CFG_L_BIT];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CFG; k++) begin
            pmpcfg_d[k] = {cfg_byte_d[4*k+3], cfg_byte_d[4*k+2],
                           cfg_byte_d[4*k+1], cfg_byte_d[4*k]};
        end
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            pmpaddr_d[e] = pmpaddr_q[e];
            if (write_acc && sel_addr && (sel_idx == 4'(e)) && !addr_locked[e]) begin
                pmpaddr_d[e] = csr_req_wdata;
            end
        end
    end

    // Response reports the value the register holds after this access
    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (sel_cfg) begin
            rsp_rdata_d = pmpcfg_d[sel_idx[1:0]];
        end else if (sel_addr) begin
            rsp_rdata_d = pmpaddr_d[sel_idx];
        end else begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CFG; k++) pmpcfg_q[k] <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) pmpaddr_q[e] <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CFG; k++) pmpcfg_q[k] <= pmpcfg_d[k];
            for (int e = 0; e < NUM_ENTRIES; e++) pmpaddr_q[e] <= pmpaddr_d[e];
            if (req_accept) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
        end
    end

    // Response FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_accept) state_d = ST_RESP;
            ST_RESP: if (csr_rsp_ready && !req_accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response FSM: outputs; a new request may enter as the old response leaves
    always_comb begin
        csr_rsp_valid = (state_q == ST_RESP);
        csr_req_ready = (state_q == ST_IDLE) || csr_rsp_ready;
    end

    assign csr_rsp_rdata = rsp_rdata_q;
    assign csr_rsp_err   = rsp_err_q;

    assign pmpaddr0_data  = pmpaddr_q[0];
    assign pmpaddr1_data  = pmpaddr_q[1];
    assign pmpaddr2_data  = pmpaddr_q[2];
    assign pmpaddr3_data  = pmpaddr_q[3];
    assign pmpaddr4_data  = pmpaddr_q[4];
    assign pmpaddr5_data  = pmpaddr_q[5];
    assign pmpaddr6_data  = pmpaddr_q[6];
    assign pmpaddr7_data  = pmpaddr_q[7];
    assign pmpaddr8_data  = pmpaddr_q[8];
    assign pmpaddr9_data  = pmpaddr_q[9];
    assign pmpaddr10_data = pmpaddr_q[10];
    assign pmpaddr11_data = pmpaddr_q[11];
    assign pmpaddr12_data = pmpaddr_q[12];
    assign pmpaddr13_data = pmpaddr_q[13];
    assign pmpaddr14_data = pmpaddr_q[14];
    assign pmpaddr15_data = pmpaddr_q[15];
    assign pmpcfg0_data   = pmpcfg_q[0];
    assign pmpcfg1_data   = pmpcfg_q[1];
    assign pmpcfg2_data   = pmpcfg_q[2];
    assign pmpcfg3_data   = pmpcfg_q[3];

endmodule

// File: tb/tb_pmp_csr_regs.sv
module tb_pmp_csr_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] pa [16];
    logic [31:0] pc [4];

    always #5 clk = ~clk;

    pmp_csr_regs dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req_valid  (req_valid),
        .csr_req_ready  (req_ready),
        .csr_req_we     (req_we),
        .csr_req_addr   (req_addr),
        .csr_req_wdata  (req_wdata),
        .csr_rsp_valid  (rsp_valid),
        .csr_rsp_ready  (rsp_ready),
        .csr_rsp_rdata  (rsp_rdata),
        .csr_rsp_err    (rsp_err),
        .pmpaddr0_data  (pa[0]),
        .pmpaddr1_data  (pa[1]),
        .pmpaddr2_data  (pa[2]),
        .pmpaddr3_data  (pa[3]),
        .pmpaddr4_data  (pa[4]),
        .pmpaddr5_data  (pa[5]),
        .pmpaddr6_data  (pa[6]),
        .pmpaddr7_data  (pa[7]),
        .pmpaddr8_data  (pa[8]),
        .pmpaddr9_data  (pa[9]),
        .pmpaddr10_data (pa[10]),
        .pmpaddr11_data (pa[11]),
        .pmpaddr12_data (pa[12]),
        .pmpaddr13_data (pa[13]),
        .pmpaddr14_data (pa[14]),
        .pmpaddr15_data (pa[15]),
        .pmpcfg0_data   (pc[0]),
        .pmpcfg1_data   (pc[1]),
        .pmpcfg2_data   (pc[2]),
        .pmpcfg3_data   (pc[3])
    );

    int checks = 0;
    int passed = 0;

    // Scoreboard entries are {err, rdata}
    logic [32:0] sb [$];
    logic [31:0] exp_rdata;
    logic        exp_err;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t        vecs [32];
    logic [31:0] exp_pa [16] = '{32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h42, 32'h0, 32'h0, 32'h0, 32'hAAAA, 32'h0, 32'h77, 32'h0};
    logic [31:0] exp_pc [4]  = '{32'h0000_8F89, 32'h0780_0780, 32'h0003_981F, 32'h8800_8D00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Push expectation on accept, pop and compare on response handshake
    logic [32:0] popped;
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("rsp_has_expectation", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                popped = sb.pop_front();
                check("rsp_rdata", rsp_rdata, popped[31:0]);
                check("rsp_err", 32'(rsp_err), 32'(popped[32]));
            end
        end
        if (rst_n && req_valid && req_ready) sb.push_back({exp_err, exp_rdata});
    end

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] erd, input logic eerr);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b1; exp_rdata = erd; exp_err = eerr;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rsp_latency", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time 100000, required completion earlier");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; exp_rdata = '0; exp_err = 1'b0;

        vecs[0]  = '{1'b1, 12'h3A0, 32'h0000_001F, 32'h0000_001F, 1'b0};
        vecs[1]  = '{1'b0, 12'h3A0, 32'h0,         32'h0000_001F, 1'b0};
        vecs[2]  = '{1'b1, 12'h3A0, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{1'b1, 12'h3A0, 32'h0000_0082, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 12'h3A0, 32'h0000_0089, 32'h0000_0089, 1'b0};
        vecs[5]  = '{1'b1, 12'h3A0, 32'h0,         32'h0000_0089, 1'b0};
        vecs[6]  = '{1'b1, 12'h3A0, 32'h0000_8F00, 32'h0000_8F89, 1'b0};
        vecs[7]  = '{1'b1, 12'h3B0, 32'h1234_5678, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 12'h3B2, 32'h0000_1000, 32'h0000_1000, 1'b0};
        vecs[9]  = '{1'b1, 12'h3B1, 32'h0000_FFFF, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 12'h3A1, 32'h0080_0080, 32'h0080_0080, 1'b0};
        vecs[11] = '{1'b1, 12'h3A1, 32'h0707_0707, 32'h0780_0780, 1'b0};
        vecs[12] = '{1'b1, 12'h3BC, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0};
        vecs[13] = '{1'b1, 12'h3A3, 32'h0000_8D00, 32'h0000_8D00, 1'b0};
        vecs[14] = '{1'b1, 12'h3BC, 32'h0000_5555, 32'h0000_AAAA, 1'b0};
        vecs[15] = '{1'b1, 12'h3BD, 32'h0000_0001, 32'h0,         1'b0};
        vecs[16] = '{1'b1, 12'h3BE, 32'h0000_0077, 32'h0000_0077, 1'b0};
        vecs[17] = '{1'b1, 12'h3A3, 32'h8800_0000, 32'h8800_8D00, 1'b0};
        vecs[18] = '{1'b1, 12'h3BE, 32'h0000_0099, 32'h0000_0077, 1'b0};
        vecs[19] = '{1'b1, 12'h3BF, 32'h0000_0001, 32'h0,         1'b0};
        vecs[20] = '{1'b1, 12'h3A2, 32'h0000_9800, 32'h0000_9800, 1'b0};
        vecs[21] = '{1'b1, 12'h3B8, 32'h0000_0042, 32'h0000_0042, 1'b0};
        vecs[22] = '{1'b1, 12'h3B9, 32'h0000_0001, 32'h0,         1'b0};
        vecs[23] = '{1'b1, 12'h3A2, 32'h0203_007F, 32'h0003_981F, 1'b0};
        vecs[24] = '{1'b0, 12'h3C0, 32'h0,         32'h0,         1'b1};
        vecs[25] = '{1'b1, 12'h3A4, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[26] = '{1'b0, 12'h3A4, 32'h0,         32'h0,         1'b1};
        vecs[27] = '{1'b1, 12'h3AF, 32'h0000_0001, 32'h0,         1'b1};
        vecs[28] = '{1'b0, 12'h3BC, 32'h0,         32'h0000_AAAA, 1'b0};
        vecs[29] = '{1'b0, 12'h3A1, 32'h0,         32'h0780_0780, 1'b0};
        vecs[30] = '{1'b0, 12'h3B2, 32'h0,         32'h0000_1000, 1'b0};
        vecs[31] = '{1'b0, 12'h39F, 32'h0,         32'h0,         1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("reset_pmpaddr%0d", i), pa[i], 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("reset_pmpcfg%0d", i), pc[i], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].erd, vecs[i].eerr);
        end

        for (int i = 0; i < 16; i++) check($sformatf("pmpaddr%0d", i), pa[i], exp_pa[i]);
        for (int i = 0; i < 4; i++) check($sformatf("pmpcfg%0d", i), pc[i], exp_pc[i]);

        // Stalled error response, with a second request waiting behind it
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h3C0; rsp_ready = 1'b0;
        exp_rdata = 32'h0; exp_err = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 12'h3B3; req_wdata = 32'h5;
        exp_rdata = 32'h5; exp_err = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_rdata", rsp_rdata, 32'd0);
            check("stall_rsp_err", 32'(rsp_err), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("unstall_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("queued_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pmpaddr3_same_cycle", pa[3], 32'h5);

        // Back-to-back reads with the consumer always ready
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_addr = 12'h3A0 + 12'(k); exp_rdata = exp_pc[k]; exp_err = 1'b0;
            @(negedge clk);
            check("b2b_req_ready", 32'(req_ready), 32'd1);
            if (k > 0) check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Reset while a response is pending
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h3B2;
        exp_rdata = 32'h1000; exp_err = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre_reset_rsp_rdata", rsp_rdata, 32'h1000);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_reset_rsp_rdata", rsp_rdata, 32'd0);
        check("async_reset_rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < 16; i++) check($sformatf("async_reset_pmpaddr%0d", i), pa[i], 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("async_reset_pmpcfg%0d", i), pc[i], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
